// File: rtl/encoder_8b10b_multi.sv
// Multi-lane 8b/10b encoder: NUM_LANES bytes per beat, running disparity
// chained lane 0 -> lane NUM_LANES-1 within a beat and carried across beats.
// One-deep registered output stage with valid/ready flow control.
module encoder_8b10b_multi #(
   parameter int NUM_LANES    = 4,
   parameter bit RD_RESET_NEG = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [8*NUM_LANES-1:0]   data_i,
   input  logic [NUM_LANES-1:0]     is_k_i,
   input  logic                     rd_load_i,
   input  logic                     rd_neg_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [10*NUM_LANES-1:0]  symbols_o,
   output logic [NUM_LANES-1:0]     k_err_o,
   output logic                     rd_neg_o
);

   // 5b/6b table, RD- column (abcdei). RD+ form is the bitwise complement
   // for unbalanced codes and for D.7; other balanced codes are fixed.
   function automatic logic [5:0] lut6(input logic [4:0] x);
      logic [5:0] c;
      c = 6'b101011;
      case (x)
         5'd0:  c = 6'b100111;
         5'd1:  c = 6'b011101;
         5'd2:  c = 6'b101101;
         5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;
         5'd5:  c = 6'b101001;
         5'd6:  c = 6'b011001;
         5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;
         5'd9:  c = 6'b100101;
         5'd10: c = 6'b010101;
         5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;
         5'd13: c = 6'b101100;
         5'd14: c = 6'b011100;
         5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;
         5'd17: c = 6'b100011;
         5'd18: c = 6'b010011;
         5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;
         5'd21: c = 6'b101010;
         5'd22: c = 6'b011010;
         5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;
         5'd25: c = 6'b100110;
         5'd26: c = 6'b010110;
         5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;
         5'd29: c = 6'b101110;
         5'd30: c = 6'b011110;
         default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // 3b/4b data table (fghj), in the form used when the block RD is negative.
   // P7 is handled separately because of the A7 substitution.
   function automatic logic [3:0] lut4_data(input logic [2:0] y);
      logic [3:0] c;
      c = 4'b1110;
      case (y)
         3'd0: c = 4'b1011;
         3'd1: c = 4'b1001;
         3'd2: c = 4'b0101;
         3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;
         3'd5: c = 4'b1010;
         3'd6: c = 4'b0110;
         default: c = 4'b1110;
      endcase
      return c;
   endfunction

   // 3b/4b for K28.y, block RD negative form. After 001111 the block RD is
   // always positive, so these are always complemented when emitted.
   function automatic logic [3:0] lut4_k28(input logic [2:0] y);
      logic [3:0] c;
      c = 4'b0111;
      case (y)
         3'd0: c = 4'b1011;
         3'd1: c = 4'b0110;
         3'd2: c = 4'b1010;
         3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;
         3'd5: c = 4'b0101;
         3'd6: c = 4'b1001;
         default: c = 4'b0111;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] ones6(input logic [5:0] c);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 6; i++) begin
         n = n + {2'b00, c[i]};
      end
      return n;
   endfunction

   function automatic logic [2:0] ones4(input logic [3:0] c);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, c[i]};
      end
      return n;
   endfunction

   // Encode one byte. Result = {k_err, rd_neg_out, abcdei, fghj}.
   function automatic logic [11:0] enc_byte(
      input logic [7:0] b,
      input logic       k,
      input logic       rd_neg
   );
      logic [4:0] x;
      logic [2:0] y;
      logic       k_ok;
      logic       k28;
      logic       comp6;
      logic       comp4;
      logic       a7;
      logic       rd_mid;
      logic       rd_out;
      logic [5:0] base6;
      logic [5:0] code6;
      logic [3:0] base4;
      logic [3:0] code4;
      logic [2:0] n6;
      logic [2:0] n4;

      x     = b[4:0];
      y     = b[7:5];
      k_ok  = k && ((x == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
                    (b == 8'hFD) || (b == 8'hFE));
      k28   = k_ok && (x == 5'd28);

      // 6b sub-block: alternate unbalanced codes and D.7 on RD+
      base6 = k28 ? 6'b001111 : lut6(x);
      comp6 = (ones6(base6) != 3'd3) || (!k28 && (x == 5'd7));
      code6 = (comp6 && !rd_neg) ? ~base6 : base6;
      n6    = ones6(code6);
      rd_mid = (n6 > 3'd3) ? 1'b0 : ((n6 < 3'd3) ? 1'b1 : rd_neg);

      // 4b sub-block: A7 for valid K.x.7 and for the run-length cases
      a7 = 1'b0;
      if (k28) begin
         base4 = lut4_k28(y);
         comp4 = 1'b1;
      end else if (y == 3'd7) begin
         a7 = k_ok ||
              (rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              (!rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
         base4 = a7 ? 4'b0111 : 4'b1110;
         comp4 = 1'b1;
      end else begin
         base4 = lut4_data(y);
         comp4 = (y == 3'd0) || (y == 3'd3) || (y == 3'd4);
      end
      code4 = (comp4 && !rd_mid) ? ~base4 : base4;
      n4    = ones4(code4);
      rd_out = (n4 > 3'd2) ? 1'b0 : ((n4 < 3'd2) ? 1'b1 : rd_mid);

      return {k && !k_ok, rd_out, code6, code4};
   endfunction

   logic                     out_valid_q;
   logic [10*NUM_LANES-1:0]  symbols_q;
   logic [NUM_LANES-1:0]     k_err_q;
   logic                     rd_neg_q;

   logic [10*NUM_LANES-1:0]  symbols_d;
   logic [NUM_LANES-1:0]     k_err_d;
   logic [NUM_LANES:0]       rd_chain;
   logic                     accept;

   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   // A load coinciding with this beat overrides the stored RD for lane 0
   assign rd_chain[0] = rd_load_i ? rd_neg_i : rd_neg_q;

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic [11:0] res;
         assign res = enc_byte(data_i[8*gi +: 8], is_k_i[gi], rd_chain[gi]);
         assign symbols_d[10*gi +: 10] = res[9:0];
         assign rd_chain[gi+1]         = res[10];
         assign k_err_d[gi]            = res[11];
      end
   endgenerate

   // Output stage and stored RD; RD only moves on accept or explicit load
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         symbols_q   <= '0;
         k_err_q     <= '0;
         rd_neg_q    <= RD_RESET_NEG;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         symbols_q   <= symbols_d;
         k_err_q     <= k_err_d;
         rd_neg_q    <= rd_chain[NUM_LANES];
      end else begin
         if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
         if (rd_load_i) begin
            rd_neg_q <= rd_neg_i;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign symbols_o   = symbols_q;
   assign k_err_o     = k_err_q;
   assign rd_neg_o    = rd_neg_q;

endmodule

// File: tb/tb_encoder_8b10b_multi.sv
// Directed bench for encoder_8b10b_multi with two lanes per beat.
module tb_encoder_8b10b_multi;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data;
   logic [1:0]  is_k;
   logic        rd_load;
   logic        rd_neg;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] symbols;
   logic [1:0]  k_err;
   logic        rd_neg_out;

   int total = 0;
   int bad   = 0;
   int rs    = -1;   // running disparity of the emitted bit stream

   encoder_8b10b_multi #(.NUM_LANES(2), .RD_RESET_NEG(1'b1)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .data_i      (data),
      .is_k_i      (is_k),
      .rd_load_i   (rd_load),
      .rd_neg_i    (rd_neg),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .symbols_o   (symbols),
      .k_err_o     (k_err),
      .rd_neg_o    (rd_neg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present one beat for one clock, then sample 1 time unit after the edge
   task automatic beat(input logic [15:0] d, input logic [1:0] k,
                       input logic ld, input logic rn);
      in_valid = 1'b1;
      data     = d;
      is_k     = k;
      rd_load  = ld;
      rd_neg   = rn;
      if (ld) rs = rn ? -1 : 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rd_load  = 1'b0;
   endtask

   // Check a freshly presented beat plus stream disparity bounds
   task automatic check_out(input string tag, input logic [19:0] exp_sym,
                            input logic [1:0] exp_kerr, input logic exp_rd);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".sym"},   {12'd0, symbols},   {12'd0, exp_sym});
      chk({tag, ".kerr"},  {30'd0, k_err},     {30'd0, exp_kerr});
      chk({tag, ".rd"},    {31'd0, rd_neg_out}, {31'd0, exp_rd});
      for (int l = 0; l < 2; l++) begin
         rs = rs + 2 * $countones(symbols[10*l +: 10]) - 10;
         chk({tag, ".disp"}, {31'd0, (rs == 1) || (rs == -1)}, 32'd1);
      end
      chk({tag, ".rdsign"}, {31'd0, rd_neg_out}, {31'd0, rs < 0});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; data = '0; is_k = '0;
      rd_load = 1'b0; rd_neg = 1'b1; out_ready = 1'b1;
      #1;
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.sym",   {12'd0, symbols},   32'd0);
      chk("rst.kerr",  {30'd0, k_err},     32'd0);
      chk("rst.rd",    {31'd0, rd_neg_out}, 32'd1);
      chk("rst.ready", {31'd0, in_ready},  32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // D0.0 in both lanes from RD-: neutral codes, RD stays negative
      beat(16'h0000, 2'b00, 1'b0, 1'b1);
      check_out("d00", {10'h274, 10'h274}, 2'b00, 1'b1);
      @(posedge clk); #1;
      chk("idle.valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: A accepted, B held off for three cycles
      out_ready = 1'b0;
      beat(16'h0000, 2'b00, 1'b0, 1'b1);
      check_out("bpA", {10'h274, 10'h274}, 2'b00, 1'b1);
      in_valid = 1'b1; data = 16'hB5B5; is_k = 2'b00;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("bp.ready", {31'd0, in_ready}, 32'd0);
         chk("bp.valid", {31'd0, out_valid}, 32'd1);
         chk("bp.hold",  {12'd0, symbols}, {12'd0, 10'h274, 10'h274});
         chk("bp.rd",    {31'd0, rd_neg_out}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out("bpB", {10'h2AA, 10'h2AA}, 2'b00, 1'b1);
      @(posedge clk); #1;
      chk("bp.nodup", {31'd0, out_valid}, 32'd0);

      // Idle RD load to RD+
      rd_load = 1'b1; rd_neg = 1'b0;
      @(posedge clk); #1;
      rd_load = 1'b0;
      rs = 1;
      chk("load.rd", {31'd0, rd_neg_out}, 32'd0);

      beat(16'h0000, 2'b00, 1'b0, 1'b1);
      check_out("d00p", {10'h18B, 10'h18B}, 2'b00, 1'b0);

      // K28.5 x2 with RD- loaded on the same edge as the accept
      beat(16'hBCBC, 2'b11, 1'b1, 1'b1);
      check_out("k285", {10'h305, 10'h0FA}, 2'b00, 1'b1);

      beat(16'hB5B5, 2'b00, 1'b0, 1'b1);
      check_out("d215", {10'h2AA, 10'h2AA}, 2'b00, 1'b1);

      // Lane 0: invalid K on 0x00 -> D0.0; lane 1: valid K23.7
      beat(16'hF700, 2'b11, 1'b0, 1'b1);
      check_out("kerr", {10'h3A8, 10'h274}, 2'b01, 1'b1);

      // D0.1 (RD flips to +) then D17.7 at RD+ (primary P7)
      beat(16'hF120, 2'b00, 1'b0, 1'b1);
      check_out("p7", {10'h231, 10'h279}, 2'b00, 1'b1);

      // A7 cases: D17.7 at RD-, D11.7 at RD+
      beat(16'hEBF1, 2'b00, 1'b0, 1'b1);
      check_out("a7", {10'h348, 10'h237}, 2'b00, 1'b1);

      // D7.0 at RD- then RD+
      beat(16'h0707, 2'b00, 1'b0, 1'b1);
      check_out("d70", {10'h074, 10'h38B}, 2'b00, 1'b1);

      // Beat ending on RD+
      beat(16'h0020, 2'b00, 1'b0, 1'b1);
      check_out("endp", {10'h18B, 10'h279}, 2'b00, 1'b0);
      @(posedge clk); #1;

      // Reset while a beat is stalled at the output
      out_ready = 1'b0;
      beat(16'hB5B5, 2'b00, 1'b0, 1'b1);
      check_out("stall", {10'h2AA, 10'h2AA}, 2'b00, 1'b0);
      @(posedge clk); #1;
      chk("stall.hold", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mrst.valid", {31'd0, out_valid}, 32'd0);
      chk("mrst.rd",    {31'd0, rd_neg_out}, 32'd1);
      chk("mrst.sym",   {12'd0, symbols},   32'd0);
      chk("mrst.ready", {31'd0, in_ready},  32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
